// File: rtl/hazard_scoreboard.sv
// E/M/W Tnew scoreboard for the five-stage MIPS core: drives stall and the D/E forwarding selects.
// Define HAZARD_MDU_EN to build the multiply/divide busy counter and its stall term.
`timescale 1ns/1ps
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_a1,
    input  logic [4:0] id_a2,
    input  logic [2:0] id_tuse_rs,
    input  logic [2:0] id_tuse_rt,
    input  logic [4:0] id_a3,
    input  logic       id_regwrite,
    input  logic [2:0] id_tnew,
    input  logic       id_md,
    input  logic       id_md_start,
    input  logic       id_md_div,
    output logic       stall,
    output logic [1:0] d_fwd_rs,
    output logic [1:0] d_fwd_rt,
    output logic [1:0] e_fwd_rs,
    output logic [1:0] e_fwd_rt,
    output logic       md_busy
);

    typedef struct packed {
        logic [4:0] a3;
        logic       regwrite;
        logic [2:0] tnew;
    } entry_t;

    // Array index doubles as the forwarding stage code: 1 = E, 2 = M, 3 = W.
    entry_t [3:1] ent_q, ent_d;
    logic   [4:0] e_a1_q, e_a1_d, e_a2_q, e_a2_d;
    logic         data_stall, md_stall;

    function automatic logic [2:0] sat_dec(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    function automatic logic hit(input entry_t e, input logic [4:0] x);
        return e.regwrite && (e.a3 == x) && (x != 5'd0);
    endfunction

    for (genvar gi = 1; gi <= 3; gi++) begin : g_stage
        if (gi == 1) begin : g_e
            assign ent_d[gi] = stall ? '0 : {id_a3, id_regwrite, sat_dec(id_tnew)};
        end else begin : g_mw
            assign ent_d[gi] = {ent_q[gi-1].a3, ent_q[gi-1].regwrite, sat_dec(ent_q[gi-1].tnew)};
        end
    end

    assign e_a1_d = stall ? 5'd0 : id_a1;
    assign e_a2_d = stall ? 5'd0 : id_a2;

    logic [3:0][4:0] op_addr;
    assign op_addr = {e_a2_q, e_a1_q, id_a2, id_a1};

    // Operands 0/1 (D stage) search E..W, operands 2/3 (E stage) search M..W.
    // Scanning oldest to youngest lets the youngest writer override.
    for (genvar gi = 0; gi < 4; gi++) begin : g_op
        localparam int YOUNGEST = (gi < 2) ? 1 : 2;
        logic [1:0] sel;
        logic [2:0] tnew;
        always_comb begin
            sel  = 2'd0;
            tnew = 3'd0;
            for (int k = 3; k >= YOUNGEST; k--) begin
                if (hit(ent_q[k], op_addr[gi])) begin
                    sel  = 2'(k);
                    tnew = ent_q[k].tnew;
                end
            end
        end
    end

    assign data_stall = ((g_op[0].sel != 2'd0) && (g_op[0].tnew > id_tuse_rs))
                     || ((g_op[1].sel != 2'd0) && (g_op[1].tnew > id_tuse_rt));
    assign stall      = data_stall || md_stall;

    // A not-yet-ready producer still reports its stage; the stall covers that case.
    assign d_fwd_rs = g_op[0].sel;
    assign d_fwd_rt = g_op[1].sel;
    assign e_fwd_rs = (g_op[2].tnew == 3'd0) ? g_op[2].sel : 2'd0;
    assign e_fwd_rt = (g_op[3].tnew == 3'd0) ? g_op[3].sel : 2'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q  <= '0;
            e_a1_q <= 5'd0;
            e_a2_q <= 5'd0;
        end else begin
            ent_q  <= ent_d;
            e_a1_q <= e_a1_d;
            e_a2_q <= e_a2_d;
        end
    end

`ifdef HAZARD_MDU_EN
    logic [3:0] md_cnt_q, md_cnt_d;

    // A start that is itself stalled is not issued, so it must not load the counter.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (id_md_start && !stall) begin
            md_cnt_d = id_md_div ? 4'd10 : 4'd5;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy  = (md_cnt_q != 4'd0);
    assign md_stall = id_md && md_busy;
`else
    logic unused_md;
    assign unused_md = ^{id_md, id_md_start, id_md_div};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios and randomized D-stage traffic, checked
// each cycle against a model that tracks what left D one, two and three edges ago.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_a1 = '0, id_a2 = '0, id_a3 = '0;
    logic [2:0] id_tuse_rs = 3'd7, id_tuse_rt = 3'd7, id_tnew = '0;
    logic       id_regwrite = 1'b0, id_md = 1'b0, id_md_start = 1'b0, id_md_div = 1'b0;
    logic       stall, md_busy;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .id_a1(id_a1), .id_a2(id_a2), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_a3(id_a3), .id_regwrite(id_regwrite), .id_tnew(id_tnew),
        .id_md(id_md), .id_md_start(id_md_start), .id_md_div(id_md_div),
        .stall(stall), .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt),
        .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt), .md_busy(md_busy)
    );

`ifdef HAZARD_MDU_EN
    localparam int MD_DIV_CYC = 10;
`else
    localparam int MD_DIV_CYC = 0;
`endif

    // Model: pipe[k] is the instruction (or bubble) that left D k edges ago; its
    // remaining latency is its issued Tnew minus its age, floored at 0.
    typedef struct {
        logic [4:0] a1, a2, a3;
        logic       rw;
        logic [2:0] t;
    } rec_t;

    rec_t pipe [1:3];
    int   cyc = 0;
    int   md_end = 0;
    int   checks = 0;
    int   failures = 0;
    bit   check_en = 1'b0;

    task automatic model_clear();
        for (int k = 1; k <= 3; k++) pipe[k] = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, rw: 1'b0, t: 3'd0};
        cyc    = 0;
        md_end = 0;
    endtask

    function automatic int tnow(input int k);
        int t;
        t = int'(pipe[k].t);
        return (t > k) ? t - k : 0;
    endfunction

    function automatic int youngest(input logic [4:0] x, input int first);
        for (int k = first; k <= 3; k++)
            if (x != 5'd0 && pipe[k].rw && pipe[k].a3 == x) return k;
        return 0;
    endfunction

    function automatic bit m_busy();
`ifdef HAZARD_MDU_EN
        return cyc < md_end;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_stall();
        int p;
        bit s;
        s = 1'b0;
        p = youngest(id_a1, 1);
        if (p != 0 && tnow(p) > int'(id_tuse_rs)) s = 1'b1;
        p = youngest(id_a2, 1);
        if (p != 0 && tnow(p) > int'(id_tuse_rt)) s = 1'b1;
        if (id_md && m_busy()) s = 1'b1;
        return s;
    endfunction

    task automatic model_edge();
        bit st;
        if (reset) begin
            model_clear();
            return;
        end
        st = m_stall();
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        if (st) pipe[1] = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, rw: 1'b0, t: 3'd0};
        else    pipe[1] = '{a1: id_a1, a2: id_a2, a3: id_a3, rw: id_regwrite, t: id_tnew};
        cyc++;
`ifdef HAZARD_MDU_EN
        if (id_md_start && !st) md_end = cyc + (id_md_div ? 10 : 5);
`endif
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int p;
        if (reset) begin
            chk("rst_stall", int'(stall), 0);
            chk("rst_d_fwd", int'({d_fwd_rs, d_fwd_rt}), 0);
            chk("rst_e_fwd", int'({e_fwd_rs, e_fwd_rt}), 0);
            chk("rst_md_busy", int'(md_busy), 0);
            return;
        end
        chk("stall", int'(stall), int'(m_stall()));
        chk("md_busy", int'(md_busy), int'(m_busy()));
        p = youngest(id_a1, 1);
        if (p == 0 || tnow(p) == 0) chk("d_fwd_rs", int'(d_fwd_rs), p);
        p = youngest(id_a2, 1);
        if (p == 0 || tnow(p) == 0) chk("d_fwd_rt", int'(d_fwd_rt), p);
        p = youngest(pipe[1].a1, 2);
        if (p == 0 || tnow(p) == 0) chk("e_fwd_rs", int'(e_fwd_rs), p);
        p = youngest(pipe[1].a2, 2);
        if (p == 0 || tnow(p) == 0) chk("e_fwd_rt", int'(e_fwd_rt), p);
    endtask

    always @(negedge clk) if (check_en) compare_all();

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_d(input int a1, input int a2, input int tr, input int tt, input int a3,
                         input int rw, input int tn, input int md, input int mds, input int mdd);
        id_a1 = 5'(a1); id_a2 = 5'(a2); id_tuse_rs = 3'(tr); id_tuse_rt = 3'(tt);
        id_a3 = 5'(a3); id_regwrite = 1'(rw); id_tnew = 3'(tn);
        id_md = 1'(md); id_md_start = 1'(mds); id_md_div = 1'(mdd);
    endtask

    task automatic nop();
        set_d(0, 0, 7, 7, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        nop();
        repeat (3) begin
            @(negedge clk);
            tick();
        end
    endtask

    task automatic rand_d();
        int u;
        id_a1 = 5'($urandom_range(0, 3));
        id_a2 = 5'($urandom_range(0, 3));
        id_a3 = 5'($urandom_range(0, 3));
        u = $urandom_range(0, 4); id_tuse_rs = (u == 4) ? 3'd7 : 3'(u);
        u = $urandom_range(0, 4); id_tuse_rt = (u == 4) ? 3'd7 : 3'(u);
        id_tnew     = 3'($urandom_range(0, 4));
        id_regwrite = 1'($urandom_range(0, 1));
        id_md       = ($urandom_range(0, 3) == 0);
        id_md_start = id_md & 1'($urandom_range(0, 1));
        id_md_div   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_st, n_b;
        model_clear();
        check_en = 1'b1;

        // Reset: even a producer-looking D instruction leaves every output at 0.
        set_d(5, 6, 0, 0, 5, 1, 3, 1, 1, 1);
        @(negedge clk);
        chk("reset_stall", int'(stall), 0);
        chk("reset_sel", int'({d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt}), 0);
        tick();
        reset = 1'b0;
        flush();

        // addu $3 then addu reading $3: no stall, forward from E.
        set_d(1, 2, 1, 1, 3, 1, 2, 0, 0, 0); @(negedge clk); tick();
        set_d(3, 0, 1, 7, 4, 1, 2, 0, 0, 0); @(negedge clk);
        chk("addu_stall", int'(stall), 0);
        chk("addu_fwd_rs", int'(d_fwd_rs), 1);
        tick();
        flush();

        // lw $5 then beq $5: two stall cycles, then forward from W, then RF.
        set_d(1, 0, 1, 7, 5, 1, 3, 0, 0, 0); @(negedge clk); tick();
        set_d(5, 0, 0, 7, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("lw_stall", int'(stall), 1);
            tick();
        end
        @(negedge clk);
        chk("lw_release", int'(stall), 0);
        chk("lw_fwd_w", int'(d_fwd_rs), 3);
        tick();
        @(negedge clk);
        chk("lw_fwd_rf", int'(d_fwd_rs), 0);
        tick();
        flush();

        // Writes to $0 never create a hazard.
        set_d(1, 0, 1, 7, 0, 1, 3, 0, 0, 0); @(negedge clk); tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("r0_stall", int'(stall), 0);
            chk("r0_fwd", int'({d_fwd_rs, d_fwd_rt}), 0);
            tick();
        end
        flush();

        // Two writers of $7: the reader follows the younger one in E.
        set_d(1, 1, 1, 1, 7, 1, 2, 0, 0, 0); @(negedge clk); tick();
        set_d(2, 2, 1, 1, 7, 1, 2, 0, 0, 0); @(negedge clk); tick();
        set_d(7, 0, 1, 7, 0, 0, 0, 0, 0, 0); @(negedge clk);
        chk("waw_stall", int'(stall), 0);
        chk("waw_fwd_rs", int'(d_fwd_rs), 1);
        tick();
        flush();

        // D forwards from M, then the same operand in E forwards from W.
        set_d(1, 0, 1, 7, 8, 1, 2, 0, 0, 0); @(negedge clk); tick();
        nop(); @(negedge clk); tick();
        set_d(8, 0, 2, 7, 0, 0, 0, 0, 0, 0); @(negedge clk);
        chk("mfwd_d_rs", int'(d_fwd_rs), 2);
        tick();
        nop(); @(negedge clk);
        chk("wfwd_e_rs", int'(e_fwd_rs), 3);
        tick();
        flush();

        // lw $5, lw $6, reader of both: rs and rt hazards on different producers.
        set_d(1, 0, 1, 7, 5, 1, 3, 0, 0, 0); @(negedge clk); tick();
        set_d(1, 0, 1, 7, 6, 1, 3, 0, 0, 0); @(negedge clk); tick();
        set_d(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("dual_stall", int'(stall), 1);
            tick();
        end
        @(negedge clk);
        chk("dual_release", int'(stall), 0);
        chk("dual_fwd_rs", int'(d_fwd_rs), 0);
        chk("dual_fwd_rt", int'(d_fwd_rt), 3);
        tick();
        flush();

        // div then mflo held in D.
        set_d(1, 2, 1, 1, 0, 0, 0, 1, 1, 1); @(negedge clk);
        chk("div_issue_stall", int'(stall), 0);
        tick();
        set_d(0, 0, 7, 7, 9, 1, 2, 1, 0, 0);
        n_st = 0; n_b = 0;
        repeat (14) begin
            @(negedge clk);
            if (stall) n_st++;
            if (md_busy) n_b++;
            tick();
        end
        chk("mdu_stall_cycles", n_st, MD_DIV_CYC);
        chk("mdu_busy_cycles", n_b, MD_DIV_CYC);
        flush();

        // Reset asserted mid-stall drops stall immediately; consumer then proceeds.
        set_d(1, 0, 1, 7, 5, 1, 3, 0, 0, 0); @(negedge clk); tick();
        set_d(5, 0, 0, 7, 0, 0, 0, 0, 0, 0); @(negedge clk);
        chk("mid_rst_pre", int'(stall), 1);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_sel", int'({d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, md_busy}), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_fwd", int'(d_fwd_rs), 0);
        tick();
        flush();

        // Randomized traffic; inputs are usually held while the model says stall.
        for (int n = 0; n < 3000; n++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_clear();
            end
            if (!(m_stall() && $urandom_range(0, 3) != 0)) rand_d();
            @(negedge clk);
            tick();
        end
        reset = 1'b0;
        flush();

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the five-stage MIPS core: tracks every in-flight register write in E/M/W with a decrementing Tnew scoreboard, compares it against the Tuse of the instruction in D, and drives the stall and forwarding selects. It sequences the D→E pipeline register: `stall` from this block is what turns the E-stage entry into a bubble. An optional counter stalls multiply/divide-unit instructions while the MDU is busy.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high; clears all scoreboard state.
- `id_a1` in 5: rs index of the D instruction.
- `id_a2` in 5: rt index of the D instruction.
- `id_tuse_rs` in 3: cycles until rs is consumed; 7 means not used.
- `id_tuse_rt` in 3: as above, for rt.
- `id_a3` in 5: destination of the D instruction.
- `id_regwrite` in 1: D instruction writes `id_a3`.
- `id_tnew` in 3: cycles from D until the result exists.
- `id_md` in 1: D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- `id_md_start` in 1: D instruction is mult/multu/div/divu.
- `id_md_div` in 1: the start is a divide.
- `stall` out 1: freeze PC and F/D; bubble into E.
- `d_fwd_rs`, `d_fwd_rt` out 2 each: D-operand source. 0 = RF, 1 = E, 2 = M, 3 = W.
- `e_fwd_rs`, `e_fwd_rt` out 2 each: E-operand source. 0 = pipeline register, 2 = M, 3 = W.
- `md_busy` out 1: MDU counter nonzero.

## Operation
- Three entries: E, M, W. Each entry holds a3, regwrite and tnew; E also holds a1 and a2. Entries with a3 = 0 or regwrite = 0 are inert.
- Each clock edge:
  - E loads the D fields, with tnew = sat(id_tnew − 1).
  - If `stall` = 1, E loads all zeros instead (bubble).
  - M loads E, with tnew = sat(E.tnew − 1).
  - W loads M, with tnew = sat(M.tnew − 1).
  - sat() floors at 0.
- Producer match for operand X (D-stage): take the youngest of E, M, W with regwrite = 1, a3 = X and X ≠ 0. Only that entry is considered.
- Data stall: the matched producer's tnew > the operand's tuse.
- `d_fwd_*`:
  - matched producer with tnew = 0 → its stage code;
  - otherwise 0.
  - When the producer's tnew ≠ 0, any select value is allowed (don't-care).
- `e_fwd_*` uses E.a1/E.a2 against the M then W entries under the same youngest-match rule, requiring tnew = 0.
- `stall` = data stall(rs) | data stall(rt) | MDU stall.
- All outputs are combinational from current state plus D inputs.

## Timing
- Reset (asynchronous) clears all entries and the MDU counter to 0.
- While `reset` is asserted: every output is 0 (`stall` 0, all selects 0, `md_busy` 0).
- `stall` and all selects are valid in the same cycle the D inputs are presented; there is no registered latency.
- The scoreboard advances every edge; the block has no enable.
- While stalled, the D inputs are held by the pipeline, so the condition is re-evaluated each cycle.
- A load in E (id_tnew was 3, so E.tnew = 2) followed by a consumer with tuse 0 stalls for 2 cycles. The consumer then forwards from W, with select 3.
- Simultaneous rs and rt hazards on different producers: `stall` is the OR of both conditions.
- A hazard that clears while the producer sits in W is the last possible case; W is gone on the next edge and the RF supplies the value (select 0).

## Configuration
- Macro: `HAZARD_MDU_EN`.
- Defined:
  - 4-bit counter. On an edge where `id_md_start` = 1 and `stall` = 0, it loads 10 if `id_md_div`, else 5.
  - Otherwise it decrements while nonzero.
  - MDU stall = `id_md` & (counter ≠ 0).
  - `md_busy` = (counter ≠ 0).
- Undefined:
  - Counter not built.
  - `id_md`, `id_md_start` and `id_md_div` are ignored.
  - MDU stall = 0 and `md_busy` tied to 0.
- Ports are identical in both builds.

## Test plan
- addu $3 (id_tnew 2) then addu using $3 as rs (tuse 1) → `stall` 0, `d_fwd_rs` 1 in the consumer's D cycle.
- lw $5 (id_tnew 3) then beq on $5 (tuse 0) → `stall` 1 for 2 cycles, then `d_fwd_rs` 3. The E entry reads a3 = 0 during the bubbles.
- Producer writing $0 (id_tnew 3) then consumer of $0 (tuse 0) → `stall` 0 and selects 0 throughout.
- Two writers of $7 back to back, then a reader of $7 → the select tracks the younger writer (E = 1), never M.
- With `HAZARD_MDU_EN`: div issued, then mflo in D → `stall` 1 for exactly 10 cycles and `md_busy` high for 10 cycles. Without the macro: no stall.
- Assert `reset` mid-stall (lw in E) → `stall` drops asynchronously and all entries read 0. After release, the same consumer proceeds with select 0.
